// File: rtl/counter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | counter_pkg: shared width, state encoding and next-count helper. Rev 1.0 |
// +--------------------------------------------------------------------------+
package counter_pkg;

  localparam int DEFAULT_WIDTH = 3;

  localparam logic [1:0] ST_ARMED = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  typedef enum logic [1:0] {
    ARMED = ST_ARMED,
    TRACK = ST_TRACK,
    FAULT = ST_FAULT
  } state_t;

  // Model of the monitored up-counter for one edge, computed modulo 2^width.
  function automatic logic [31:0] next_count(input logic [31:0] value,
                                             input logic        en,
                                             input int          width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return en ? ((value + 32'd1) & mask) : (value & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_counter_checker_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sat_counter: event counter, saturating or free-wrapping. Rev 1.0         |
// +--------------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic step_ok;

  generate
    if (SATURATE) begin : g_sat
      assign step_ok = inc && (count != MAX_VAL);
    end else begin : g_wrap
      assign step_ok = inc;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (step_ok) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mod_counter_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mod_counter_checker: passive predictor/checker for a mod-2^WIDTH counter |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mod_counter_checker
  import counter_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int ERR_W        = 8,
  parameter int WRAP_W       = 8,
  parameter int FAULT_THRESH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [WIDTH-1:0]  count_in,
  output logic [WIDTH-1:0]  expected,
  output logic              locked,
  output logic              mismatch,
  output logic              fault,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;
  localparam logic [4:0]       THRESH    = 5'(FAULT_THRESH);

  state_t           state, state_next;
  logic [3:0]       miss_run, miss_run_next;
  logic             wrap_pend, wrap_pend_next;
  logic [WIDTH-1:0] expected_next;
  logic [4:0]       run_inc;
  logic             hit, fault_hit, err_inc, wrap_inc;

  always_comb begin
    hit            = 1'b0;
    run_inc        = {1'b0, miss_run} + 5'd1;
    fault_hit      = 1'b0;
    miss_run_next  = 4'd0;
    state_next     = state;
    // An unknown count_in fails the equality and is treated as a miss.
    if (count_in == expected) begin
      hit = 1'b1;
    end
    if (!hit) begin
      miss_run_next = (miss_run == 4'hF) ? 4'hF : run_inc[3:0];
      fault_hit     = (run_inc >= THRESH);
    end
    // Always resync to the observed value so one glitch costs one miss.
    expected_next  = WIDTH'(next_count(32'(count_in), enable, WIDTH));
    wrap_pend_next = enable && (count_in == MAX_COUNT);
    case (state)
      ARMED, TRACK: state_next = fault_hit ? FAULT : TRACK;
      FAULT:        state_next = FAULT;
      default:      state_next = ARMED;
    endcase
  end

  assign err_inc  = !hit;
  assign wrap_inc = hit && wrap_pend && (state != FAULT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARMED;
      expected  <= '0;
      locked    <= 1'b0;
      mismatch  <= 1'b0;
      fault     <= 1'b0;
      miss_run  <= 4'd0;
      wrap_pend <= 1'b0;
    end else begin
      state     <= state_next;
      expected  <= expected_next;
      locked    <= (state_next == TRACK) && hit;
      mismatch  <= !hit;
      fault     <= (state_next == FAULT);
      miss_run  <= miss_run_next;
      wrap_pend <= wrap_pend_next;
    end
  end

  sat_counter #(
    .WIDTH    (ERR_W),
    .SATURATE (1'b1)
  ) u_err_count (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (err_inc),
    .count (err_count)
  );

  sat_counter #(
    .WIDTH    (WRAP_W),
    .SATURATE (1'b0)
  ) u_wrap_count (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (wrap_inc),
    .count (wrap_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_mod_counter_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mod_counter_checker: directed vectors with queued expected responses. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mod_counter_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] count_in = 3'd0;
  logic [2:0] expected;
  logic       locked, mismatch, fault;
  logic [7:0] err_count, wrap_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] exp;
    logic       locked;
    logic       mis;
    logic       fault;
    logic [7:0] err;
    logic [7:0] wrap;
  } resp_t;

  resp_t q[$];

  // Reference state of the checker as seen after each edge.
  logic [2:0] m_exp = 3'd0;
  logic [1:0] m_state = 2'd0;
  logic [3:0] m_run = 4'd0;
  logic       m_wpend = 1'b0, m_locked = 1'b0, m_mis = 1'b0, m_fault = 1'b0;
  logic [7:0] m_err = 8'd0, m_wrap = 8'd0;

  mod_counter_checker dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .count_in   (count_in),
    .expected   (expected),
    .locked     (locked),
    .mismatch   (mismatch),
    .fault      (fault),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic e, input logic [2:0] c);
    logic h;
    @(negedge clk);
    reset = r; enable = e; count_in = c;
    h = (c == m_exp);
    if (r) begin
      m_exp = 0; m_state = 0; m_run = 0; m_wpend = 0;
      m_locked = 0; m_mis = 0; m_fault = 0; m_err = 0; m_wrap = 0;
    end else begin
      m_mis = !h;
      if (!h) begin
        if (m_err != 8'hFF) m_err = m_err + 1;
        if (m_run != 4'hF) m_run = m_run + 1;
      end else begin
        m_run = 0;
      end
      if (h && m_wpend && m_state != 2'd2) m_wrap = m_wrap + 1;
      m_wpend = e && (c == 3'd7);
      m_exp = e ? c + 3'd1 : c;
      if (!h && m_run >= 4'd3) m_state = 2'd2;
      else if (m_state == 2'd0) m_state = 2'd1;
      m_fault  = (m_state == 2'd2);
      m_locked = (m_state == 2'd1) && h;
    end
    q.push_back('{m_exp, m_locked, m_mis, m_fault, m_err, m_wrap});
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always begin
    resp_t r;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      r = q.pop_front();
      checks++;
      if ({expected, locked, mismatch, fault, err_count, wrap_count} !== r) begin
        errors++;
        $display("FAIL cycle_resp: got exp=%0d lock=%0b mis=%0b flt=%0b err=%0d wrap=%0d, expected exp=%0d lock=%0b mis=%0b flt=%0b err=%0d wrap=%0d",
                 expected, locked, mismatch, fault, err_count, wrap_count,
                 r.exp, r.locked, r.mis, r.fault, r.err, r.wrap);
      end
    end
  end

  initial begin
    // Reset held for two cycles.
    step(1, 1, 0); step(1, 1, 0);
    settle();
    chk("reset_err", err_count, 0);
    chk("reset_locked", locked, 0);
    chk("reset_expected", expected, 0);

    // Correct counter 0..7,0,1.
    step(0, 1, 0);
    settle();
    chk("first_locked", locked, 1);
    for (int i = 1; i < 10; i++) step(0, 1, 3'(i));
    settle();
    chk("run_err", err_count, 0);
    chk("run_wrap", wrap_count, 1);

    // Enable low with the count holding at 3, then resume.
    step(0, 1, 2);
    step(0, 0, 3); step(0, 0, 3); step(0, 0, 3);
    settle();
    chk("hold_expected", expected, 3);
    step(0, 1, 3);
    settle();
    chk("resume_expected", expected, 4);
    step(0, 1, 4);

    // Single skip 3->5.
    step(0, 1, 5); step(0, 1, 6); step(0, 1, 7); step(0, 1, 0);
    step(0, 1, 1); step(0, 1, 2); step(0, 1, 3); step(0, 1, 5);
    settle();
    chk("skip_mis", mismatch, 1);
    chk("skip_err", err_count, 1);
    chk("skip_locked", locked, 0);
    step(0, 1, 6);
    settle();
    chk("skip_relock", locked, 1);
    chk("skip_mis_clear", mismatch, 0);

    // Stuck at 2 -> sticky fault.
    step(0, 1, 7); step(0, 1, 0); step(0, 1, 1); step(0, 1, 2);
    step(0, 1, 2); step(0, 1, 2); step(0, 1, 2);
    settle();
    chk("stuck_fault", fault, 1);
    chk("stuck_locked", locked, 0);
    chk("stuck_err", err_count, 4);
    step(0, 1, 3); step(0, 1, 4);
    settle();
    chk("fault_sticky", fault, 1);
    chk("fault_unlocked", locked, 0);

    // Reset mid-run, bad then good first value.
    step(1, 1, 6); step(0, 1, 4);
    settle();
    chk("bad_first_mis", mismatch, 1);
    chk("bad_first_err", err_count, 1);
    step(1, 1, 5); step(0, 1, 0);
    settle();
    chk("good_first_mis", mismatch, 0);
    chk("good_first_err", err_count, 0);
    chk("good_first_wrap", wrap_count, 0);
    chk("good_first_fault", fault, 0);

    // 260 isolated mismatches with enable low.
    step(0, 0, 1);
    for (int i = 0; i < 130; i++) begin
      step(0, 0, 5); step(0, 0, 5); step(0, 0, 1); step(0, 0, 1);
    end
    settle();
    chk("sat_err", err_count, 255);
    chk("sat_no_fault", fault, 0);
    step(0, 0, 6);
    settle();
    chk("sat_mis_pulse", mismatch, 1);
    chk("sat_hold", err_count, 255);

    settle(); settle();
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
